// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB interconnect: FSM state encoding,
// default bus widths and width helpers.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 32;
    localparam int unsigned APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DECERR
    } apb_state_e;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Slave index width; never narrower than one bit so a single-slave build stays legal.
    function automatic int unsigned idx_width(input int unsigned num_slaves);
        return (num_slaves > 1) ? $clog2(num_slaves) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Base/mask address decoder with a lowest-index-wins priority encoder.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int unsigned                       ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int unsigned                       NUM_SLAVES = 2,
    parameter int unsigned                       IDX_W      = idx_width(NUM_SLAVES),
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_MASK = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                         SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/apb_interconnect.sv
// APB 1-to-N interconnect with latched request and registered decode.
// Optional ACCESS timeout is enabled by defining APB_INTERCONNECT_TIMEOUT_EN.
module apb_interconnect
    import apb_pkg::*;
#(
    parameter int unsigned                       ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int unsigned                       DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned                       NUM_SLAVES     = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_BASE     = {32'h0000_0000, 32'h0000_0400},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_MASK     = {32'hFFFF_F000, 32'hFFFF_FFFC},
    parameter int unsigned                       TIMEOUT_CYCLES = 64
) (
    input  logic                               pclk,
    input  logic                               presetn,
    input  logic [ADDR_WIDTH-1:0]              paddr,
    input  logic [DATA_WIDTH-1:0]              pwdata,
    input  logic                               pwrite,
    input  logic [strb_width(DATA_WIDTH)-1:0]  pstrb,
    input  logic                               psel,
    input  logic                               penable,
    output logic [DATA_WIDTH-1:0]              prdata,
    output logic                               pready,
    output logic                               pslverr,
    output logic [NUM_SLAVES-1:0]              s_psel,
    output logic                               s_penable,
    output logic [ADDR_WIDTH-1:0]              s_paddr,
    output logic [DATA_WIDTH-1:0]              s_pwdata,
    output logic                               s_pwrite,
    output logic [strb_width(DATA_WIDTH)-1:0]  s_pstrb,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   s_prdata,
    input  logic [NUM_SLAVES-1:0]              s_pready,
    input  logic [NUM_SLAVES-1:0]              s_pslverr
);

    localparam int unsigned IDX_W  = idx_width(NUM_SLAVES);
    localparam int unsigned STRB_W = strb_width(DATA_WIDTH);

    apb_state_e             state;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [DATA_WIDTH-1:0]  lat_wdata;
    logic                   lat_write;
    logic [STRB_W-1:0]      lat_strb;
    logic [IDX_W-1:0]       lat_idx;

    logic                   dec_hit;
    logic [IDX_W-1:0]       dec_idx;
    logic                   sel_ready;
    logic                   sel_err;
    logic [DATA_WIDTH-1:0]  sel_rdata;
    logic                   timeout;

    apb_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .addr (paddr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Response mux for the latched slave index.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (lat_idx == IDX_W'(i)) begin
                sel_ready = s_pready[i];
                sel_err   = s_pslverr[i];
                sel_rdata = s_prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef APB_INTERCONNECT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !sel_ready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // A slave ready in the same cycle takes precedence over the forced error.
    assign timeout = (state == ACCESS) && !sel_ready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            lat_strb  <= '0;
            lat_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        lat_addr  <= paddr;
                        lat_wdata <= pwdata;
                        lat_write <= pwrite;
                        lat_strb  <= pstrb;
                        lat_idx   <= dec_idx;
                        state     <= dec_hit ? SETUP : DECERR;
                    end
                end
                SETUP:   state <= ACCESS;
                ACCESS:  if (sel_ready || timeout) state <= IDLE;
                DECERR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign s_paddr   = lat_addr;
    assign s_pwdata  = lat_wdata;
    assign s_pwrite  = lat_write;
    assign s_pstrb   = lat_strb;
    assign s_penable = (state == ACCESS);

    always_comb begin
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            s_psel[i] = ((state == SETUP) || (state == ACCESS)) && (lat_idx == IDX_W'(i));
        end
    end

    // Master-side completion is gated by psel so an aborted transfer drains silently.
    always_comb begin
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        case (state)
            ACCESS: begin
                if (psel) begin
                    pready  = sel_ready || timeout;
                    pslverr = sel_ready ? sel_err : timeout;
                    prdata  = sel_ready ? sel_rdata : '0;
                end
            end
            DECERR: begin
                pready  = 1'b1;
                pslverr = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
